// File: rtl/gsu_code_cache_if.sv
// Fetch and ROM handshake bundle for the GSU code cache.
// master = the cache itself, slave = core/ROM environment around it.
interface gsu_code_cache_if;
   logic        fetch_req;
   logic        fetch_ready;
   logic        fetch_valid;
   logic [15:0] fetch_pc;
   logic [7:0]  fetch_pbr;
   logic [7:0]  fetch_data;
   logic        rom_req;
   logic        rom_ack;
   logic [23:0] rom_addr;
   logic [7:0]  rom_data;

   modport master (
      input  fetch_req, fetch_pc, fetch_pbr, rom_ack, rom_data,
      output fetch_ready, fetch_valid, fetch_data, rom_req, rom_addr
   );

   modport slave (
      output fetch_req, fetch_pc, fetch_pbr, rom_ack, rom_data,
      input  fetch_ready, fetch_valid, fetch_data, rom_req, rom_addr
   );
endinterface

// File: rtl/gsu_code_cache.sv
// GSU code cache: CBR-relative byte cache with line fill from ROM,
// out-of-window bypass, SNES-side window access and deferred invalidation.
module gsu_code_cache #(
   parameter int LINE_BYTES = 16,
   parameter int NUM_LINES  = 32
) (
   input  logic                                    clkin,
   input  logic                                    RST,
   gsu_code_cache_if.master                        bus,
   input  logic                                    cbr_wr,
   input  logic [15:0]                             cbr_in,
   input  logic                                    cache_flush,
   input  logic                                    snes_wr,
   input  logic [$clog2(LINE_BYTES*NUM_LINES)-1:0] snes_addr,
   input  logic [7:0]                              snes_di,
   output logic [7:0]                              snes_do,
   output logic [15:0]                             cbr_out,
   output logic [NUM_LINES-1:0]                    line_valid
);
   localparam int CACHE_BYTES = LINE_BYTES * NUM_LINES;
   localparam int AW = $clog2(CACHE_BYTES);
   localparam int OW = $clog2(LINE_BYTES);
   localparam int LW = AW - OW;

   typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_FILL, S_BYPASS, S_RESP} state_t;
   state_t r_state, w_state_next;

   logic [15:0]          r_cbr, r_pend_cbr, r_pc;
   logic [7:0]           r_pbr, r_fetch_data, r_snes_do;
   logic                 r_pend, r_pend_cbr_wr;
   logic [OW-1:0]        r_k;
   logic [NUM_LINES-1:0] r_valid, w_valid_next;
   logic [7:0]           r_ram [CACHE_BYTES];

   logic [15:0]   w_off, w_cbr_in_m, w_fill_addr, w_cbr_next;
   logic          w_in_range, w_hit, w_accept, w_apply, w_fill_done;
   logic          w_snes_we, w_snes_set, w_ram_we, w_fill_we;
   logic [LW-1:0] w_line, w_snes_line;
   logic [AW-1:0] w_ram_idx, w_fill_idx, w_snes_idx, w_waddr;
   logic [7:0]    w_wdata;
   logic          w_fetch_ready, w_fetch_valid, w_rom_req;
   logic [23:0]   w_rom_addr;

   // Fetch address decode relative to the cache base.
   assign w_off       = r_pc - r_cbr;
   assign w_in_range  = (w_off < 16'(CACHE_BYTES));
   assign w_line      = w_off[AW-1:OW];
   assign w_ram_idx   = w_off[AW-1:0];
   assign w_hit       = w_in_range && r_valid[w_line];
   assign w_fill_idx  = {w_line, r_k};
   assign w_fill_addr = r_cbr + 16'(w_fill_idx);
   assign w_cbr_in_m  = cbr_in & ~16'(LINE_BYTES - 1);

   // SNES window: offset is added to CBR and folded into the RAM.
   assign w_snes_idx  = snes_addr + r_cbr[AW-1:0];
   assign w_snes_line = w_snes_idx[AW-1:OW];
   assign w_snes_we   = snes_wr && (r_state == S_IDLE);
   assign w_snes_set  = w_snes_we && (&w_snes_idx[OW-1:0]);

   assign w_accept    = w_fetch_ready && bus.fetch_req;
   assign w_fill_we   = (r_state == S_FILL) && bus.rom_ack;
   assign w_fill_done = w_fill_we && (&r_k);

   // Invalidation lands immediately in IDLE; otherwise it is held and
   // applied on the RESP->IDLE edge so a running fetch still completes.
   always_comb begin
      w_apply = 1'b0;
      if (r_state == S_IDLE)
         w_apply = cbr_wr || cache_flush;
      else if (r_state == S_RESP)
         w_apply = r_pend || cbr_wr || cache_flush;
   end

   assign w_cbr_next = cbr_wr ? w_cbr_in_m : (r_pend_cbr_wr ? r_pend_cbr : r_cbr);

   // Single RAM write port shared by SNES writes (IDLE only) and ROM fills.
   assign w_ram_we = !RST && (w_snes_we || w_fill_we);
   assign w_waddr  = w_snes_we ? w_snes_idx : w_fill_idx;
   assign w_wdata  = w_snes_we ? snes_di : bus.rom_data;

   // Valid flags: invalidation wins over any flag set in the same cycle.
   always_comb begin
      w_valid_next = r_valid;
      if (w_apply) begin
         w_valid_next = '0;
      end else begin
         if (w_fill_done) w_valid_next[w_line] = 1'b1;
         if (w_snes_set)  w_valid_next[w_snes_line] = 1'b1;
      end
   end

   // State register.
   always_ff @(posedge clkin) begin
      if (RST) r_state <= S_IDLE;
      else     r_state <= w_state_next;
   end

   // Next-state and handshake outputs.
   always_comb begin
      w_state_next  = r_state;
      w_fetch_ready = 1'b0;
      w_fetch_valid = 1'b0;
      w_rom_req     = 1'b0;
      w_rom_addr    = '0;
      case (r_state)
         S_IDLE: begin
            w_fetch_ready = !snes_wr && !r_pend;
            if (!snes_wr && !r_pend && bus.fetch_req) w_state_next = S_LOOKUP;
         end
         S_LOOKUP: begin
            if (!w_in_range) w_state_next = S_BYPASS;
            else if (w_hit)  w_state_next = S_RESP;
            else             w_state_next = S_FILL;
         end
         S_FILL: begin
            w_rom_req  = 1'b1;
            w_rom_addr = {r_pbr, w_fill_addr};
            if (bus.rom_ack && (&r_k)) w_state_next = S_LOOKUP;
         end
         S_BYPASS: begin
            w_rom_req  = 1'b1;
            w_rom_addr = {r_pbr, r_pc};
            if (bus.rom_ack) w_state_next = S_RESP;
         end
         S_RESP: begin
            w_fetch_valid = 1'b1;
            w_state_next  = S_IDLE;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // Control/datapath registers: CBR, pending invalidate, fetch latch, fill counter, flags.
   always_ff @(posedge clkin) begin
      if (RST) begin
         r_cbr         <= '0;
         r_pend        <= 1'b0;
         r_pend_cbr_wr <= 1'b0;
         r_pend_cbr    <= '0;
         r_pc          <= '0;
         r_pbr         <= '0;
         r_k           <= '0;
         r_valid       <= '0;
         r_fetch_data  <= '0;
      end else begin
         r_valid <= w_valid_next;
         if (w_apply) begin
            r_cbr         <= w_cbr_next;
            r_pend        <= 1'b0;
            r_pend_cbr_wr <= 1'b0;
         end else if ((r_state != S_IDLE) && (cbr_wr || cache_flush)) begin
            r_pend <= 1'b1;
            if (cbr_wr) begin
               r_pend_cbr_wr <= 1'b1;
               r_pend_cbr    <= w_cbr_in_m;
            end
         end
         if (w_accept) begin
            r_pc  <= bus.fetch_pc;
            r_pbr <= bus.fetch_pbr;
         end
         if (r_state == S_LOOKUP) r_k <= '0;
         else if (w_fill_we)      r_k <= r_k + 1'b1;
         if ((r_state == S_LOOKUP) && w_hit)
            r_fetch_data <= r_ram[w_ram_idx];
         else if ((r_state == S_BYPASS) && bus.rom_ack)
            r_fetch_data <= bus.rom_data;
      end
   end

   // Cache RAM write port.
   always_ff @(posedge clkin) begin
      if (w_ram_we) r_ram[w_waddr] <= w_wdata;
   end

   // SNES read port, registered, reads in every state.
   always_ff @(posedge clkin) begin
      if (RST) r_snes_do <= '0;
      else     r_snes_do <= r_ram[w_snes_idx];
   end

   assign bus.fetch_ready = w_fetch_ready;
   assign bus.fetch_valid = w_fetch_valid;
   assign bus.fetch_data  = r_fetch_data;
   assign bus.rom_req     = w_rom_req;
   assign bus.rom_addr    = w_rom_addr;
   assign snes_do         = r_snes_do;
   assign cbr_out         = r_cbr;
   assign line_valid      = r_valid;
endmodule

// File: tb/tb_gsu_code_cache.sv
// Directed bench for gsu_code_cache: scoreboard queues for expected ROM
// addresses and fetch bytes, a 1-cycle-ack ROM model, immediate assertions.
module tb_gsu_code_cache;
   localparam int LB = 16;
   localparam int NL = 32;
   localparam int AW = 9;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cbr_wr = 1'b0;
   logic          cache_flush = 1'b0;
   logic          snes_wr = 1'b0;
   logic [15:0]   cbr_in = '0;
   logic [AW-1:0] snes_addr = '0;
   logic [7:0]    snes_di = '0;
   logic [7:0]    snes_do;
   logic [15:0]   cbr_out;
   logic [NL-1:0] line_valid;

   always #5 clk = ~clk;

   gsu_code_cache_if bus();

   gsu_code_cache #(.LINE_BYTES(LB), .NUM_LINES(NL)) dut (
      .clkin       (clk),
      .RST         (rst),
      .bus         (bus),
      .cbr_wr      (cbr_wr),
      .cbr_in      (cbr_in),
      .cache_flush (cache_flush),
      .snes_wr     (snes_wr),
      .snes_addr   (snes_addr),
      .snes_di     (snes_di),
      .snes_do     (snes_do),
      .cbr_out     (cbr_out),
      .line_valid  (line_valid)
   );

   int checks = 0;
   int errors = 0;
   int n_ack = 0;
   int n_valid = 0;
   logic [7:0]  exp_q[$];
   logic [23:0] exp_rom_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: every fetch_valid pops one expected byte.
   always @(negedge clk) begin
      if (bus.fetch_valid === 1'b1) begin
         n_valid++;
         $display("fetch response data=%02h", bus.fetch_data);
         check("valid_expected", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0)
            check("fetch_data", {24'h0, bus.fetch_data}, {24'h0, exp_q.pop_front()});
      end
   end

   // ROM model: acks every requested cycle, data = low address byte + 0x10.
   always @(negedge clk) begin
      if (bus.rom_req === 1'b1) begin
         bus.rom_ack  = 1'b1;
         bus.rom_data = bus.rom_addr[7:0] + 8'h10;
         n_ack++;
         check("rom_expected", 32'(exp_rom_q.size() != 0), 32'd1);
         if (exp_rom_q.size() != 0)
            check("rom_addr", {8'h0, bus.rom_addr}, {8'h0, exp_rom_q.pop_front()});
      end else begin
         bus.rom_ack = 1'b0;
      end
   end

   task automatic fill_exp(input logic [7:0] pbr, input logic [15:0] base, input int n);
      for (int k = 0; k < n; k++) exp_rom_q.push_back({pbr, base + 16'(k)});
   endtask

   task automatic fetch(input logic [15:0] pc, input logic [7:0] pbr);
      bus.fetch_pc  = pc;
      bus.fetch_pbr = pbr;
      bus.fetch_req = 1'b1;
      #1;
      check("fetch_ready", {31'h0, bus.fetch_ready}, 32'd1);
      tick();
      bus.fetch_req = 1'b0;
   endtask

   task automatic wait_resp(input string tag);
      int start;
      start = n_valid;
      for (int i = 0; i < 100 && n_valid == start; i++) tick();
      check(tag, n_valid - start, 32'd1);
   endtask

   task automatic load_cbr(input logic [15:0] v);
      cbr_wr = 1'b1;
      cbr_in = v;
      tick();
      cbr_wr = 1'b0;
   endtask

   initial begin
      int a;
      int v0;
      bus.fetch_req = 1'b0;
      bus.fetch_pc  = '0;
      bus.fetch_pbr = '0;
      bus.rom_ack   = 1'b0;
      bus.rom_data  = '0;

      // Reset values
      repeat (3) tick();
      check("rst_snes_do", {24'h0, snes_do}, 32'h0);
      rst = 1'b0;
      check("rst_ready", {31'h0, bus.fetch_ready}, 32'd1);
      check("rst_valid", {31'h0, bus.fetch_valid}, 32'd0);
      check("rst_rom_req", {31'h0, bus.rom_req}, 32'd0);
      check("rst_rom_addr", {8'h0, bus.rom_addr}, 32'h0);
      check("rst_fetch_data", {24'h0, bus.fetch_data}, 32'h0);
      check("rst_cbr", {16'h0, cbr_out}, 32'h0);
      check("rst_line_valid", line_valid, 32'h0);

      // Miss on line 0: 16-byte fill then response
      a = n_ack;
      fill_exp(8'h01, 16'h0000, 16);
      exp_q.push_back(8'h15);
      fetch(16'h0005, 8'h01);
      wait_resp("resp_fill0");
      check("fill0_acks", n_ack - a, 32'd16);
      check("fill0_line_valid", line_valid, 32'h1);

      // Hit: fetch_valid exactly 2 cycles after accept, no ROM traffic
      a = n_ack;
      exp_q.push_back(8'h19);
      fetch(16'h0009, 8'h01);
      check("hit_lookup_valid", {31'h0, bus.fetch_valid}, 32'd0);
      tick();
      check("hit_latency", {31'h0, bus.fetch_valid}, 32'd1);
      tick();
      check("hit_pulse", {31'h0, bus.fetch_valid}, 32'd0);
      check("hit_no_rom", n_ack - a, 32'd0);

      // CBR load masks low bits and invalidates; first byte past window bypasses
      load_cbr(16'h8007);
      check("cbr_masked", {16'h0, cbr_out}, 32'h8000);
      check("cbr_inval", line_valid, 32'h0);
      a = n_ack;
      exp_rom_q.push_back(24'h018200);
      exp_q.push_back(8'h10);
      fetch(16'h8200, 8'h01);
      wait_resp("resp_bypass");
      check("bypass_acks", n_ack - a, 32'd1);
      check("bypass_no_valid", line_valid, 32'h0);

      // Last byte of the window fills the last line
      fill_exp(8'h01, 16'h81F0, 16);
      exp_q.push_back(8'h0F);
      fetch(16'h81FF, 8'h01);
      wait_resp("resp_lastline");
      check("lastline_valid", line_valid, 32'h8000_0000);
      a = n_ack;
      exp_q.push_back(8'h03);
      fetch(16'h81F3, 8'h01);
      wait_resp("resp_lastline_hit");
      check("lastline_hit_no_rom", n_ack - a, 32'd0);

      // SNES fills line 1; flag sets on the last byte only
      load_cbr(16'h0000);
      check("cbr_zero", {16'h0, cbr_out}, 32'h0);
      for (int i = 0; i < 16; i++) begin
         if (i == 15) check("snes_partial", line_valid, 32'h0);
         snes_wr   = 1'b1;
         snes_addr = AW'(16 + i);
         snes_di   = 8'hA0 + 8'(i);
         #1;
         if (i == 0) check("snes_blocks_ready", {31'h0, bus.fetch_ready}, 32'd0);
         tick();
      end
      snes_wr = 1'b0;
      check("snes_line_valid", line_valid, 32'h2);
      snes_addr = 9'h013;
      tick();
      check("snes_readback", {24'h0, snes_do}, 32'hA3);
      a = n_ack;
      exp_q.push_back(8'hA3);
      fetch(16'h0013, 8'h01);
      wait_resp("resp_snes_hit");
      check("snes_hit_no_rom", n_ack - a, 32'd0);

      // Flush during fill of line 2: fill completes, then all flags clear
      a = n_ack;
      fill_exp(8'h01, 16'h0020, 16);
      exp_q.push_back(8'h35);
      fetch(16'h0025, 8'h01);
      repeat (3) tick();
      cache_flush = 1'b1;
      snes_wr     = 1'b1;
      snes_addr   = 9'h010;
      snes_di     = 8'h55;
      tick();
      cache_flush = 1'b0;
      snes_wr     = 1'b0;
      wait_resp("resp_flush_fill");
      tick();
      tick();
      check("flush_acks", n_ack - a, 32'd16);
      check("flush_line_valid", line_valid, 32'h0);
      check("flush_cbr", {16'h0, cbr_out}, 32'h0);
      tick();
      check("busy_snes_ignored", {24'h0, snes_do}, 32'hA0);
      a = n_ack;
      fill_exp(8'h01, 16'h0020, 16);
      exp_q.push_back(8'h35);
      fetch(16'h0025, 8'h01);
      wait_resp("resp_refill");
      check("refill_acks", n_ack - a, 32'd16);
      check("refill_valid", line_valid, 32'h4);

      // Reset on the 5th ack of a fill aborts it
      load_cbr(16'h0040);
      check("cbr_40", {16'h0, cbr_out}, 32'h40);
      n_ack = 0;
      v0 = n_valid;
      fill_exp(8'h01, 16'h0040, 5);
      fetch(16'h0045, 8'h01);
      for (int i = 0; i < 60 && n_ack < 4; i++) tick();
      check("abort_ack4", n_ack, 32'd4);
      rst = 1'b1;
      tick();
      check("abort_ack5", n_ack, 32'd5);
      check("abort_rom_req", {31'h0, bus.rom_req}, 32'd0);
      check("abort_line_valid", line_valid, 32'h0);
      check("abort_cbr", {16'h0, cbr_out}, 32'h0);
      check("abort_valid", {31'h0, bus.fetch_valid}, 32'd0);
      rst = 1'b0;
      repeat (5) tick();
      check("abort_no_resp", n_valid - v0, 32'd0);
      check("abort_ready", {31'h0, bus.fetch_ready}, 32'd1);
      check("rom_q_drained", exp_rom_q.size(), 32'd0);
      check("data_q_drained", exp_q.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
